// File: rtl/vga_timing_if.sv
// Timing outputs of vga_timing, bundled so producers and consumers share one port.
interface vga_timing_if;
   logic [10:0] hpos;
   logic [10:0] vpos;
   logic        hsync;
   logic        vsync;
   logic        display_on;
   logic        pix_tick;
   logic        frame_start;

   modport master (
      output hpos, vpos, hsync, vsync, display_on, pix_tick, frame_start
   );

   modport slave (
      input hpos, vpos, hsync, vsync, display_on, pix_tick, frame_start
   );
endinterface

// File: rtl/vga_timing.sv
// VGA sync/position generator; all outputs registered and aligned with hpos/vpos.
// Define VGA_PIXEL_DIV_EN to advance the counters on every second clk (clk/2 pixel rate).
module vga_timing #(
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned H_PULSE = 96,
   parameter int unsigned H_FRONT = 16,
   parameter int unsigned H_DISP  = 640,
   parameter int unsigned V_TOTAL = 521,
   parameter int unsigned V_PULSE = 2,
   parameter int unsigned V_FRONT = 10,
   parameter int unsigned V_DISP  = 480
) (
   input  logic         clk,
   input  logic         rst,
   vga_timing_if.master vga
);

   localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
   localparam logic [10:0] VLast      = 11'(V_TOTAL - 1);
   localparam logic [10:0] HSyncEnd   = 11'(H_PULSE);
   localparam logic [10:0] VSyncEnd   = 11'(V_PULSE);
   localparam logic [10:0] HDispStart = 11'(H_PULSE + H_FRONT);
   localparam logic [10:0] HDispEnd   = 11'(H_PULSE + H_FRONT + H_DISP);
   localparam logic [10:0] VDispStart = 11'(V_PULSE + V_FRONT);
   localparam logic [10:0] VDispEnd   = 11'(V_PULSE + V_FRONT + V_DISP);

   logic [10:0] hpos_q, hpos_d;
   logic [10:0] vpos_q, vpos_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        display_on_q, display_on_d;
   logic        frame_start_q, frame_start_d;
   logic        pix_tick_q, pix_tick_d;
`ifdef VGA_PIXEL_DIV_EN
   logic        tog_q, tog_d;
`endif

   always_comb begin
      hpos_d        = hpos_q;
      vpos_d        = vpos_q;
      frame_start_d = 1'b0;
      if (pix_tick_q) begin
         if (hpos_q == HLast) begin
            hpos_d = '0;
            if (vpos_q == VLast) begin
               vpos_d        = '0;
               frame_start_d = 1'b1;
            end else begin
               vpos_d = vpos_q + 11'd1;
            end
         end else begin
            hpos_d = hpos_q + 11'd1;
         end
      end

      // Decode from next-state counters so syncs land on the same edge as the position.
      hsync_d      = (hpos_d >= HSyncEnd);
      vsync_d      = (vpos_d >= VSyncEnd);
      display_on_d = (hpos_d >= HDispStart) && (hpos_d < HDispEnd) &&
                     (vpos_d >= VDispStart) && (vpos_d < VDispEnd);

`ifdef VGA_PIXEL_DIV_EN
      // Tick lands on the second edge after reset release, then every other edge.
      tog_d      = ~tog_q;
      pix_tick_d = tog_q;
`else
      pix_tick_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hpos_q        <= '0;
         vpos_q        <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         display_on_q  <= 1'b0;
         frame_start_q <= 1'b0;
         pix_tick_q    <= 1'b0;
`ifdef VGA_PIXEL_DIV_EN
         tog_q         <= 1'b0;
`endif
      end else begin
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         frame_start_q <= frame_start_d;
         pix_tick_q    <= pix_tick_d;
`ifdef VGA_PIXEL_DIV_EN
         tog_q         <= tog_d;
`endif
      end
   end

   assign vga.hpos        = hpos_q;
   assign vga.vpos        = vpos_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.display_on  = display_on_q;
   assign vga.pix_tick    = pix_tick_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_TOTAL, 800, pixel clocks per line.
REQ-002 Parameter H_PULSE, 96, hsync pulse width in pixel ticks.
REQ-003 Parameter H_FRONT, 16, ticks between the end of hsync and the first visible pixel.
REQ-004 Parameter H_DISP, 640, visible pixels per line.
REQ-005 Parameter V_TOTAL, 521, lines per frame.
REQ-006 Parameter V_PULSE, 2, vsync pulse width in lines.
REQ-007 Parameter V_FRONT, 10, lines between the end of vsync and the first visible line.
REQ-008 Parameter V_DISP, 480, visible lines per frame.
REQ-009 Port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-010 Port rst, input, 1, reset, asynchronous and active-high.
REQ-011 Port hpos, output, 11, horizontal counter, range 0..H_TOTAL-1.
REQ-012 Port vpos, output, 11, vertical counter, range 0..V_TOTAL-1.
REQ-013 Port hsync, output, 1, active-low horizontal sync.
REQ-014 Port vsync, output, 1, active-low vertical sync.
REQ-015 Port display_on, output, 1, high when (hpos, vpos) is in the visible window.
REQ-016 Port pix_tick, output, 1, high in the clk cycles where the counters advance at the next edge.
REQ-017 Port frame_start, output, 1, one-clk pulse marking the start of each frame.

Function
REQ-018 The counters shall advance only in cycles where pix_tick=1.
- hpos increments by 1.
- At hpos=H_TOTAL-1, hpos wraps to 0 and vpos increments.
- At hpos=H_TOTAL-1 and vpos=V_TOTAL-1, both wrap to 0 on the same edge.
REQ-019 hsync shall be 0 when hpos<H_PULSE, and 1 otherwise.
REQ-020 vsync shall be 0 when vpos<V_PULSE, and 1 otherwise.
REQ-021 display_on shall be 1 only under both of these conditions:
- H_PULSE+H_FRONT <= hpos < H_PULSE+H_FRONT+H_DISP (112..751 at defaults);
- V_PULSE+V_FRONT <= vpos < V_PULSE+V_FRONT+V_DISP (12..491 at defaults).
REQ-022 hsync, vsync and display_on shall be registered and consistent with the hpos/vpos values present in the same cycle, with zero skew.
REQ-023 frame_start shall be 1 for exactly one clk: the first clk cycle in which (hpos, vpos)=(0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-024 Counter arithmetic shall be 11-bit unsigned, and counters shall never hold values at or above H_TOTAL/V_TOTAL.
REQ-025 hsync shall pulse every line, including the vertical blanking lines.

Reset
REQ-026 While rst=1, outputs shall hold these values:
- hpos=0, vpos=0;
- hsync=0, vsync=0;
- display_on=0, frame_start=0, pix_tick=0.
REQ-027 Assertion of rst mid-frame shall force the REQ-026 values immediately, without waiting for a clk edge.
REQ-028 After rst deasserts, counting shall resume from (0,0).
REQ-029 No frame_start pulse shall be emitted for the post-reset frame; the first frame_start follows the first full wrap.

Configuration
REQ-030 The macro VGA_PIXEL_DIV_EN shall select the pixel-tick rate.
- Defined: an internal toggle divides clk by 2; pix_tick=1 on every second clk, and the first pix_tick occurs 2 clks after reset release. This targets a 50 MHz clk with a 25 MHz pixel rate.
- Undefined: pix_tick=1 on every clk after reset release, and the counters advance every clk.
REQ-031 All other behaviour shall be identical with and without VGA_PIXEL_DIV_EN.

Verification
REQ-032 Reset and release:
- Apply rst=1 mid-frame -> within the same cycle hpos=0, vpos=0, hsync=0, vsync=0, display_on=0.
- Release rst -> hsync rises when hpos reaches 96.
REQ-033 Line wrap: hpos=799, vpos=5, pix_tick=1 -> next edge gives hpos=0, vpos=6, hsync=0, and frame_start remains 0.
REQ-034 Frame wrap: hpos=799, vpos=520 -> next edge gives (0,0), vsync=0, and frame_start=1 for exactly one clk, including in VGA_PIXEL_DIV_EN builds.
REQ-035 Visible-window edges at vpos=12:
- display_on=0 at hpos=111 and 1 at hpos=112;
- display_on=1 at hpos=751 and 0 at hpos=752.
- Same checks at vpos=491 (inside, display_on=1 at hpos=112) and vpos=492 (display_on=0 throughout).
REQ-036 Frame period: consecutive frame_start pulses shall be 416800 clks apart with the macro undefined, and 833600 clks apart with VGA_PIXEL_DIV_EN defined.
REQ-037 Sync widths: each line's hsync shall be low for exactly 96 pix_ticks, and vsync shall be low for exactly 1600 pix_ticks (2 lines).
